// File: rtl/bcd_display_scan.sv
// Four-digit multiplexed BCD to seven-segment scanner with sticky bad-digit flag.
// Optional leading-zero blanking is enabled by defining LEAD_ZERO_BLANK_EN.
module bcd_display_scan #(
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        load,
  input  logic [15:0] bcd,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        err,
  output logic        frame
);

  localparam logic [15:0] PMAX = 16'(SCAN_DIV - 1);

  logic [15:0] r_pre;
  logic [1:0]  r_idx;
  logic [15:0] r_disp;

  logic        w_last;
  logic [3:0]  w_nib;
  logic [3:0]  w_an;
  logic [6:0]  w_dec;
  logic [6:0]  w_seg;
  logic        w_bad;

  always_comb begin
    w_last = (r_pre == PMAX);
    w_nib  = r_disp[{r_idx, 2'b00} +: 4];
    w_an   = 4'b0001 << r_idx;
  end

  always_comb begin
    w_dec = 7'b1111001;
    case (w_nib)
      4'd0: w_dec = 7'b0111111;
      4'd1: w_dec = 7'b0000110;
      4'd2: w_dec = 7'b1011011;
      4'd3: w_dec = 7'b1001111;
      4'd4: w_dec = 7'b1100110;
      4'd5: w_dec = 7'b1101101;
      4'd6: w_dec = 7'b1111101;
      4'd7: w_dec = 7'b0000111;
      4'd8: w_dec = 7'b1111111;
      4'd9: w_dec = 7'b1101111;
      default: w_dec = 7'b1111001;
    endcase
  end

`ifdef LEAD_ZERO_BLANK_EN
  logic w_blank;

  // Digit 0 always shows, so a zero value still reads "0".
  always_comb begin
    w_blank = 1'b0;
    unique case (1'b1)
      (r_idx == 2'd3): w_blank = ~|r_disp[15:12];
      (r_idx == 2'd2): w_blank = ~|r_disp[15:8];
      (r_idx == 2'd1): w_blank = ~|r_disp[15:4];
      default:         w_blank = 1'b0;
    endcase
    w_seg = w_blank ? 7'b0000000 : w_dec;
  end
`else
  always_comb begin
    w_seg = w_dec;
  end
`endif

  always_comb begin
    w_bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (bcd[i*4 +: 4] > 4'd9) w_bad = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_pre  <= '0;
      r_idx  <= '0;
      r_disp <= '0;
      seg    <= '0;
      an     <= '0;
      err    <= 1'b0;
      frame  <= 1'b0;
    end else begin
      r_pre <= w_last ? 16'd0 : r_pre + 16'd1;
      if (w_last) r_idx <= r_idx + 2'd1;
      if (load) r_disp <= bcd;
      if (load && w_bad) err <= 1'b1;
      an    <= w_an;
      seg   <= w_seg;
      frame <= w_last && (r_idx == 2'd3);
    end
  end

endmodule
